eth_transmitter_p: RTL

Parametrised successor to the Ethernet transmit front-end. The CPU fills a byte buffer through the asynchronous memory-style bus (a/d/n_we/n_oe/n_rdy). It then starts a transmission of a programmable length, which is shifted out on a serial clock/data pair (tx_sck/tx_mosi) to the Ethernet controller. Generalises the fixed 1 KiB, whole-buffer, LSB-first transmitter with: configurable depth, programmable length, clock divider, bit order, inter-byte gap and abort.

---
 rtl/eth_transmitter_p.sv | 120 ++++++++++++
 1 files changed

// File: rtl/eth_transmitter_p.sv
// eth_transmitter_p: bus-loaded byte buffer shifted out on tx_sck/tx_mosi with programmable length, divider, bit order, gap and abort
module eth_transmitter_p #(
  parameter int          BUF_AW    = 10,
  parameter logic [15:0] BUF_BASE  = 16'hF000,
  parameter logic [15:0] CR_ADDR   = 16'hFB00,
  parameter int          CLK_DIV   = 2,
  parameter bit          MSB_FIRST = 1'b0,
  parameter int          BYTE_GAP  = 0
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [15:0] a,
  inout  wire  [7:0]  d,
  input  logic        n_we,
  input  logic        n_oe,
  output logic        n_rdy,
  output logic        tx_sck,
  output logic        tx_mosi,
  output logic        tx_busy
);
  typedef enum logic [2:0] {IDLE, LOAD, LOW, HIGH, GAP} state_t;
  localparam int GAP_N = BYTE_GAP * 2 * CLK_DIV;
  localparam logic [BUF_AW:0] DEPTH = {1'b1, {BUF_AW{1'b0}}};
  localparam logic [BUF_AW:0] ONE = {{BUF_AW{1'b0}}, 1'b1};
  state_t state;
  logic [7:0] mem [2**BUF_AW];
  logic we_s1, we_s2, oe_s1, oe_s2, seen, ack, aborted;
  logic act, do_acc, wr_acc, buf_hit, cr_hit, st_hit, lo_hit, hi_hit, hit;
  logic [15:0] len, div_cnt, gap_cnt;
  logic [BUF_AW:0] idx, cur_len, eff_len;
  logic [BUF_AW-1:0] mem_addr;
  logic [7:0] sh, rdata, rd;
  logic [2:0] bit_cnt;
  assign act = ~we_s2 | ~oe_s2;
  assign do_acc = act & seen & ~ack & (state != LOAD);
  assign wr_acc = do_acc & ~we_s2;
  assign buf_hit = a[15:BUF_AW] == BUF_BASE[15:BUF_AW];
  assign cr_hit = a == CR_ADDR;
  assign st_hit = a == CR_ADDR + 16'd1;
  assign lo_hit = a == CR_ADDR + 16'd2;
  assign hi_hit = a == CR_ADDR + 16'd3;
  assign hit = buf_hit | cr_hit | st_hit | lo_hit | hi_hit;
  assign n_rdy = ~(ack & act);
  assign d = (~n_oe & hit) ? rdata : 8'hzz;
  assign mem_addr = (state == LOAD) ? idx[BUF_AW-1:0] : a[BUF_AW-1:0];
  assign rd = mem[mem_addr];
  assign eff_len = (len == 16'd0 || 32'(len) >= 32'(DEPTH)) ? DEPTH : len[BUF_AW:0];
  always_ff @(posedge clk)
    if (wr_acc & buf_hit) mem[a[BUF_AW-1:0]] <= d;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      {we_s1, we_s2, oe_s1, oe_s2} <= 4'hf;
      {seen, ack, aborted} <= 3'b000;
      {tx_sck, tx_mosi, tx_busy} <= 3'b000;
      state <= IDLE;
      len <= '0;
      idx <= '0;
      cur_len <= '0;
      sh <= '0;
      rdata <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      {we_s1, we_s2, oe_s1, oe_s2} <= {n_we, we_s1, n_oe, oe_s1};
      seen <= act;
      ack <= act & (ack | do_acc);
      if (do_acc & we_s2)
        rdata <= buf_hit ? rd : cr_hit ? {6'd0, tx_busy, aborted} : lo_hit ? len[7:0] : hi_hit ? len[15:8] : 8'd0;
      if (wr_acc & lo_hit) len[7:0] <= d;
      if (wr_acc & hi_hit) len[15:8] <= d;
      if (wr_acc & cr_hit & d[0] & (state != IDLE)) begin
        state <= IDLE;
        {tx_sck, tx_mosi, tx_busy} <= 3'b000;
        aborted <= 1'b1;
      end else
        case (state)
          IDLE: if (wr_acc & st_hit) begin
            cur_len <= eff_len;
            aborted <= 1'b0;
            idx <= '0;
            tx_busy <= 1'b1;
            state <= LOAD;
          end
          LOAD: begin
            sh <= rd;
            bit_cnt <= '0;
            div_cnt <= '0;
            tx_mosi <= MSB_FIRST ? rd[7] : rd[0];
            state <= LOW;
          end
          LOW: if (div_cnt == 16'(CLK_DIV - 1)) begin
            div_cnt <= '0;
            tx_sck <= 1'b1;
            state <= HIGH;
          end else div_cnt <= div_cnt + 16'd1;
          HIGH: if (div_cnt != 16'(CLK_DIV - 1)) div_cnt <= div_cnt + 16'd1;
          else begin
            div_cnt <= '0;
            tx_sck <= 1'b0;
            if (bit_cnt != 3'd7) begin
              bit_cnt <= bit_cnt + 3'd1;
              sh <= MSB_FIRST ? sh << 1 : sh >> 1;
              tx_mosi <= MSB_FIRST ? sh[6] : sh[1];
              state <= LOW;
            end else if (idx + ONE == cur_len) begin
              tx_busy <= 1'b0;
              state <= IDLE;
            end else begin
              idx <= idx + ONE;
              gap_cnt <= '0;
              state <= (GAP_N == 0) ? LOAD : GAP;
            end
          end
          GAP: if (gap_cnt == 16'(GAP_N - 1)) state <= LOAD;
          else gap_cnt <= gap_cnt + 16'd1;
          default: state <= IDLE;
        endcase
    end
endmodule
